// File: rtl/burst_write_gen.sv
// Burst/gap write-traffic source for the FIFO write port; first we_o 1 cycle after an accepted start.
// Backpressure: we_o follows wrdy_i in BURST; when stallable it holds position on a stall, otherwise the word is dropped.
module burst_write_gen #(
   parameter int LEN_W     = 8,
   parameter int NB_W      = 8,
   parameter int CNT_W     = 16,
   parameter int STALLABLE = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] burst_len_i,
   input  logic [LEN_W-1:0] idle_len_i,
   input  logic [NB_W-1:0]  num_bursts_i,
   input  logic             wrdy_i,
   output logic             we_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] words_o,
   output logic [CNT_W-1:0] stalls_o,
   output logic [CNT_W-1:0] drops_o
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q, idle_q, word_cnt, gap_cnt;
   logic [NB_W-1:0]   nb_q, burst_cnt;
   logic [CNT_W-1:0]  words_q, stalls_q, drops_q;
   logic              start_ok, advance, last_word, last_burst, last_gap;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign start_ok   = (state == S_IDLE) && start_i && !abort_i &&
                       (burst_len_i != '0) && (num_bursts_i != '0);
   // A free-running source moves on every cycle; a stallable one only on accept.
   assign advance    = (STALLABLE != 0) ? wrdy_i : 1'b1;
   assign last_word  = (word_cnt == len_q - 1'b1);
   assign last_burst = (burst_cnt == nb_q - 1'b1);
   assign last_gap   = (gap_cnt == idle_q - 1'b1);

   always_comb begin
      state_nxt = state;
      we_o      = 1'b0;
      done_o    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_ok) state_nxt = S_BURST;
         end
         S_BURST: begin
            we_o = wrdy_i;
            if (advance && last_word) begin
               if (last_burst)          state_nxt = S_DONE;
               else if (idle_q != '0)   state_nxt = S_GAP;
               else                     state_nxt = S_BURST;
            end
         end
         S_GAP: begin
            if (last_gap) state_nxt = S_BURST;
         end
         S_DONE: begin
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort_i) begin
         state_nxt = S_IDLE;
         we_o      = 1'b0;
         done_o    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= S_IDLE;
         len_q     <= '0;
         idle_q    <= '0;
         nb_q      <= '0;
         word_cnt  <= '0;
         gap_cnt   <= '0;
         burst_cnt <= '0;
         words_q   <= '0;
         stalls_q  <= '0;
         drops_q   <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            len_q     <= burst_len_i;
            idle_q    <= idle_len_i;
            nb_q      <= num_bursts_i;
            word_cnt  <= '0;
            gap_cnt   <= '0;
            burst_cnt <= '0;
            words_q   <= '0;
            stalls_q  <= '0;
            drops_q   <= '0;
         end else if (!abort_i) begin
            if (state == S_BURST) begin
               if (advance) begin
                  if (last_word) begin
                     word_cnt  <= '0;
                     gap_cnt   <= '0;
                     burst_cnt <= burst_cnt + 1'b1;
                  end else begin
                     word_cnt  <= word_cnt + 1'b1;
                  end
               end
               if (wrdy_i) begin
                  words_q <= sat_inc(words_q);
               end else begin
                  stalls_q <= sat_inc(stalls_q);
                  if (STALLABLE == 0) drops_q <= sat_inc(drops_q);
               end
            end else if (state == S_GAP) begin
               gap_cnt <= gap_cnt + 1'b1;
            end
         end
      end
   end

   assign busy_o   = (state != S_IDLE);
   assign words_o  = words_q;
   assign stalls_o = stalls_q;
   assign drops_o  = drops_q;

endmodule

// File: tb/tb_burst_write_gen.sv
// Bench for burst_write_gen: three instances (stallable, free-running, 4-bit counters) share one
// stimulus stream; expected per-cycle outputs come from a schedule built from the run parameters.
module tb_burst_write_gen;

   localparam int MAXC = 1024;

   typedef struct packed {
      logic        we;
      logic        busy;
      logic        done;
      logic [15:0] words;
      logic [15:0] stalls;
      logic [15:0] drops;
   } obs_t;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic [7:0] burst_len_i = '0;
   logic [7:0] idle_len_i = '0;
   logic [7:0] num_bursts_i = '0;
   logic       wrdy_i = 1'b0;

   logic [2:0]  we_w, busy_w, done_w;
   logic [15:0] wd_w [3];
   logic [15:0] st_w [3];
   logic [15:0] dr_w [3];
   logic [3:0]  sat_wd, sat_st, sat_dr;

   int checks = 0;
   int failures = 0;

   obs_t        exp_a [3][MAXC];
   int          exp_n [3];
   obs_t        fin [3];
   logic [15:0] pw [3];
   logic [15:0] ps [3];
   logic [15:0] pd [3];
   logic        wr [MAXC];
   bit          stl [3];
   logic [15:0] cmax [3];
   int          obs_len [3];
   int          done_seen [3];
   logic [63:0] we_hist [3];
   bit          chk_en = 1'b0;
   int          cur = 0;

   always #5 clk_i = ~clk_i;

   burst_write_gen #(.LEN_W(8), .NB_W(8), .CNT_W(16), .STALLABLE(1)) u_stl (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .burst_len_i(burst_len_i), .idle_len_i(idle_len_i), .num_bursts_i(num_bursts_i),
      .wrdy_i(wrdy_i), .we_o(we_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
      .words_o(wd_w[0]), .stalls_o(st_w[0]), .drops_o(dr_w[0]));

   burst_write_gen #(.LEN_W(8), .NB_W(8), .CNT_W(16), .STALLABLE(0)) u_drp (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .burst_len_i(burst_len_i), .idle_len_i(idle_len_i), .num_bursts_i(num_bursts_i),
      .wrdy_i(wrdy_i), .we_o(we_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
      .words_o(wd_w[1]), .stalls_o(st_w[1]), .drops_o(dr_w[1]));

   burst_write_gen #(.LEN_W(8), .NB_W(8), .CNT_W(4), .STALLABLE(1)) u_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .burst_len_i(burst_len_i), .idle_len_i(idle_len_i), .num_bursts_i(num_bursts_i),
      .wrdy_i(wrdy_i), .we_o(we_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]),
      .words_o(sat_wd), .stalls_o(sat_st), .drops_o(sat_dr));

   assign wd_w[2] = {12'd0, sat_wd};
   assign st_w[2] = {12'd0, sat_st};
   assign dr_w[2] = {12'd0, sat_dr};

   task automatic chk(input string name, input int v, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, v, cur, act, expv);
      end
   endtask

   function automatic logic [15:0] sat(input logic [15:0] x, input int v);
      return (x >= cmax[v]) ? x : x + 16'd1;
   endfunction

   function automatic obs_t mk(input logic we, input logic busy, input logic done,
                               input logic [15:0] w, input logic [15:0] s, input logic [15:0] d);
      obs_t o;
      o.we = we; o.busy = busy; o.done = done; o.words = w; o.stalls = s; o.drops = d;
      return o;
   endfunction

   // Index 0 is the start cycle; run cycles follow. Counters shown in a cycle cover earlier cycles only.
   task automatic gen(input int v, input int len, input int idl, input int nb, input int ab);
      int i, k;
      bit stop;
      logic [15:0] wd, st, dr;
      exp_a[v][0] = mk(1'b0, 1'b0, 1'b0, pw[v], ps[v], pd[v]);
      i = 1;
      stop = 1'b0;
      if (len != 0 && nb != 0) begin
         wd = '0; st = '0; dr = '0;
         for (int b = 0; b < nb && !stop; b++) begin
            k = 0;
            while (k < len && !stop) begin
               if (i == ab) begin
                  exp_a[v][i] = mk(1'b0, 1'b1, 1'b0, wd, st, dr);
                  stop = 1'b1;
               end else begin
                  exp_a[v][i] = mk(wr[i], 1'b1, 1'b0, wd, st, dr);
                  if (wr[i]) wd = sat(wd, v);
                  else begin
                     st = sat(st, v);
                     if (!stl[v]) dr = sat(dr, v);
                  end
                  if (wr[i] || !stl[v]) k++;
               end
               i++;
            end
            if (b < nb - 1) begin
               for (int g = 0; g < idl && !stop; g++) begin
                  exp_a[v][i] = mk(1'b0, 1'b1, 1'b0, wd, st, dr);
                  if (i == ab) stop = 1'b1;
                  i++;
               end
            end
         end
         if (!stop) begin
            exp_a[v][i] = mk(1'b0, 1'b1, (i != ab), wd, st, dr);
            i++;
         end
         pw[v] = wd; ps[v] = st; pd[v] = dr;
      end
      exp_n[v] = i;
      fin[v] = mk(1'b0, 1'b0, 1'b0, pw[v], ps[v], pd[v]);
   endtask

   always @(negedge clk_i) begin
      if (chk_en) begin
         for (int v = 0; v < 3; v++) begin
            obs_t e;
            e = (cur < exp_n[v]) ? exp_a[v][cur] : fin[v];
            chk("we", v, {15'd0, we_w[v]}, {15'd0, e.we});
            chk("busy", v, {15'd0, busy_w[v]}, {15'd0, e.busy});
            chk("done", v, {15'd0, done_w[v]}, {15'd0, e.done});
            chk("words", v, wd_w[v], e.words);
            chk("stalls", v, st_w[v], e.stalls);
            chk("drops", v, dr_w[v], e.drops);
            chk("we_while_full", v, {15'd0, we_w[v] & ~wrdy_i}, 16'd0);
            if (busy_w[v] && !done_w[v]) begin
               obs_len[v]++;
               we_hist[v] = {we_hist[v][62:0], we_w[v]};
            end
            if (done_w[v]) done_seen[v]++;
         end
      end
   end

   // mode 0: wrdy always 1; 1: random (~25% full); 2: full on indices z0..z1
   task automatic run(input int len, input int idl, input int nb, input int mode,
                      input int z0, input int z1, input int ab);
      int t;
      for (int i = 0; i < MAXC; i++) begin
         if (mode == 1 && i < 600) wr[i] = ($urandom_range(0, 3) != 0);
         else if (mode == 2)       wr[i] = !(i >= z0 && i <= z1);
         else                      wr[i] = 1'b1;
      end
      t = 0;
      for (int v = 0; v < 3; v++) begin
         gen(v, len, idl, nb, ab);
         if (exp_n[v] > t) t = exp_n[v];
         obs_len[v] = 0;
         done_seen[v] = 0;
         we_hist[v] = '0;
      end
      t = t + 2;
      for (int i = 0; i < t; i++) begin
         @(posedge clk_i);
         #1;
         cur = i;
         chk_en = 1'b1;
         start_i = (i == 0);
         abort_i = (i == ab);
         wrdy_i = wr[i];
         if (i == 0) begin
            burst_len_i = len[7:0];
            idle_len_i = idl[7:0];
            num_bursts_i = nb[7:0];
         end else begin
            burst_len_i = 8'($urandom);
            idle_len_i = 8'($urandom);
            num_bursts_i = 8'($urandom);
         end
      end
      @(posedge clk_i);
      #1;
      chk_en = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
   endtask

   initial begin
      stl[0] = 1'b1; stl[1] = 1'b0; stl[2] = 1'b1;
      cmax[0] = 16'hFFFF; cmax[1] = 16'hFFFF; cmax[2] = 16'h000F;
      for (int v = 0; v < 3; v++) begin
         pw[v] = '0; ps[v] = '0; pd[v] = '0;
      end

      #12;
      for (int v = 0; v < 3; v++) begin
         chk("rst_busy", v, {15'd0, busy_w[v]}, 16'd0);
         chk("rst_we", v, {15'd0, we_w[v]}, 16'd0);
         chk("rst_done", v, {15'd0, done_w[v]}, 16'd0);
         chk("rst_words", v, wd_w[v] | st_w[v] | dr_w[v], 16'd0);
      end
      #11 rst_ni = 1'b1;

      run(4, 2, 3, 0, 0, 0, -1);
      chk("t1_len", 0, 16'(obs_len[0]), 16'd16);
      chk("t1_pattern", 0, we_hist[0][15:0], 16'b1111001111001111);
      chk("t1_words", 0, wd_w[0], 16'd12);
      chk("t1_stalls", 0, st_w[0], 16'd0);
      chk("t1_done", 0, 16'(done_seen[0]), 16'd1);

      run(3, 0, 2, 0, 0, 0, -1);
      chk("t2_len", 0, 16'(obs_len[0]), 16'd6);
      chk("t2_pattern", 0, we_hist[0][15:0], 16'b0000000000111111);
      chk("t2_words", 0, wd_w[0], 16'd6);

      run(8, 0, 1, 2, 4, 6, -1);
      chk("t3_len", 0, 16'(obs_len[0]), 16'd11);
      chk("t3_words", 0, wd_w[0], 16'd8);
      chk("t3_stalls", 0, st_w[0], 16'd3);
      chk("t3_drops", 0, dr_w[0], 16'd0);
      chk("t4_len", 1, 16'(obs_len[1]), 16'd8);
      chk("t4_words", 1, wd_w[1], 16'd5);
      chk("t4_stalls", 1, st_w[1], 16'd3);
      chk("t4_drops", 1, dr_w[1], 16'd3);

      run(4, 2, 4, 0, 0, 0, 8);
      chk("t5_words", 0, wd_w[0], 16'd5);
      chk("t5_done", 0, 16'(done_seen[0]), 16'd0);
      chk("t5_busy", 0, {15'd0, busy_w[0]}, 16'd0);

      run(0, 1, 3, 0, 0, 0, -1);
      chk("t5_len0_busy", 0, 16'(obs_len[0]), 16'd0);
      chk("t5_len0_words", 0, wd_w[0], 16'd5);

      run(20, 0, 1, 0, 0, 0, -1);
      chk("t6_sat_words", 2, wd_w[2], 16'd15);
      chk("t6_full_words", 0, wd_w[0], 16'd20);

      for (int r = 0; r < 40; r++) begin
         int ab;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
         run(int'($urandom_range(1, 12)), int'($urandom_range(0, 5)),
             int'($urandom_range(1, 4)), 1, 0, 0, ab);
      end

      @(posedge clk_i);
      #1;
      start_i = 1'b1; burst_len_i = 8'd5; idle_len_i = 8'd0; num_bursts_i = 8'd2; wrdy_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      for (int v = 0; v < 3; v++) begin
         chk("arst_busy", v, {15'd0, busy_w[v]}, 16'd0);
         chk("arst_we", v, {15'd0, we_w[v]}, 16'd0);
         chk("arst_done", v, {15'd0, done_w[v]}, 16'd0);
         chk("arst_words", v, wd_w[v], 16'd0);
      end
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cur);
      $fatal(1, "timeout");
   end

endmodule
